// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
//   Immediate-extension stage with a two-entry elastic buffer (output
//   register plus skid register). It accepts a raw immediate with a mode and
//   a sideband tag, extends it to OUT_W bits, and presents the result
//   downstream under a valid/ready handshake. It sustains one item per cycle
//   when downstream is always ready.
//
// Parameters
//   IN_W     raw immediate width
//   OUT_W    extended result width (must be >= IN_W+2)
//   TAG_W    sideband tag width
//   COUNT_W  output-transfer counter width
//
// Ports
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   in_valid    upstream item present
//   in_ready    registered accept indication (0 only when both entries full)
//   in_imm      raw immediate
//   in_mode     00 sext, 01 zext, 10 upper-load, 11 branch offset (sext << 2)
//   in_tag      sideband tag carried with the item
//   out_valid   result present (state ONE or TWO)
//   out_ready   downstream accepts result
//   out_data    extended result
//   out_tag     tag of the presented result
//   xfer_count  number of output transfers, wrapping
module imm_extend_pipe #(
  parameter int IN_W    = 16,
  parameter int OUT_W   = 32,
  parameter int TAG_W   = 5,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_imm,
  input  logic [1:0]         in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic [COUNT_W-1:0] xfer_count
);

  // The branch-offset mode needs two spare bits above the sign-extended
  // immediate so the left shift never loses significance.
  generate
    if (OUT_W < IN_W + 2) begin : g_bad_params
      $error("imm_extend_pipe: OUT_W must be at least IN_W+2");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam int EXT_W = OUT_W - IN_W;

  function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm,
                                              input logic [1:0]      mode);
    logic [OUT_W-1:0] sx;
    logic [OUT_W-1:0] zx;
    logic [OUT_W-1:0] up;
    sx = {{EXT_W{imm[IN_W-1]}}, imm};
    zx = {{EXT_W{1'b0}}, imm};
    up = {imm, {EXT_W{1'b0}}};
    case (mode)
      2'b00:   extend = sx;
      2'b01:   extend = zx;
      2'b10:   extend = up;
      default: extend = sx << 2;
    endcase
  endfunction

  state_e             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;
  logic [OUT_W-1:0]   skid_data_q, skid_data_d;
  logic [TAG_W-1:0]   skid_tag_q, skid_tag_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  logic             in_xfer;
  logic             out_xfer;
  logic [OUT_W-1:0] ext_data;

  assign ext_data  = extend(in_imm, in_mode);
  assign out_valid = (state_q != ST_EMPTY);
  assign in_xfer   = in_valid && in_ready_q;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    skid_data_d = skid_data_q;
    skid_tag_d  = skid_tag_q;
    cnt_d       = cnt_q;

    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          state_d    = ST_ONE;
          out_data_d = ext_data;
          out_tag_d  = in_tag;
        end
      end
      ST_ONE: begin
        if (in_xfer && !out_xfer) begin
          // Output held by downstream: park the new item in the skid.
          state_d     = ST_TWO;
          skid_data_d = ext_data;
          skid_tag_d  = in_tag;
        end else if (!in_xfer && out_xfer) begin
          // Output register keeps its old contents while empty.
          state_d = ST_EMPTY;
        end else if (in_xfer && out_xfer) begin
          out_data_d = ext_data;
          out_tag_d  = in_tag;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only the drain path can fire.
        if (out_xfer) begin
          state_d    = ST_ONE;
          out_data_d = skid_data_q;
          out_tag_d  = skid_tag_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (out_xfer) cnt_d = cnt_q + {{(COUNT_W-1){1'b0}}, 1'b1};

    // Registered ready: looks at the next state only, never at out_ready
    // in the current cycle.
    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      skid_data_q <= '0;
      skid_tag_q  <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      skid_data_q <= skid_data_d;
      skid_tag_q  <= skid_tag_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_data   = out_data_q;
  assign out_tag    = out_tag_q;
  assign xfer_count = cnt_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: a default-parameter instance and a COUNT_W=4
// instance driven by identical stimulus. A scoreboard queue of expected
// results is filled on input transfers and drained on output transfers;
// directed checks cover latency, modes, back-pressure, reset and wrap.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_imm = '0;
  logic [1:0]  in_mode = '0;
  logic [4:0]  in_tag = '0;

  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic [15:0] xfer_count;

  logic        in_ready4, out_valid4;
  logic [31:0] out_data4;
  logic [4:0]  out_tag4;
  logic [3:0]  xfer_count4;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  tag;
  } item_t;
  item_t sb[$];

  imm_extend_pipe dut (
    .clk(clk), .reset_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .xfer_count(xfer_count)
  );

  imm_extend_pipe #(.COUNT_W(4)) dut4 (
    .clk(clk), .reset_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .out_tag(out_tag4), .xfer_count(xfer_count4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference extension written with integer arithmetic.
  function automatic logic [31:0] model(input logic [15:0] imm, input logic [1:0] mode);
    int s;
    s = $signed(imm);
    case (mode)
      2'd0:    model = s;
      2'd1:    model = {16'h0000, imm};
      2'd2:    model = {imm, 16'h0000};
      default: model = s * 4;
    endcase
  endfunction

  // Scoreboard: evaluated on the falling edge, i.e. the handshake state
  // that the next rising edge will act on.
  always @(negedge clk) begin : mon
    item_t e;
    if (rst_n) begin
      chk("count", {48'd0, xfer_count}, {48'd0, exp_cnt[15:0]});
      chk("count4", {60'd0, xfer_count4}, {60'd0, exp_cnt[3:0]});
      if (out_valid && out_ready) begin
        chk("sb_nonempty", {63'd0, sb.size() != 0}, 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("sb_data", {32'd0, out_data}, {32'd0, e.data});
          chk("sb_tag", {59'd0, out_tag}, {59'd0, e.tag});
          chk("sb_data4", {32'd0, out_data4}, {32'd0, e.data});
          chk("sb_tag4", {59'd0, out_tag4}, {59'd0, e.tag});
        end
        exp_cnt++;
      end
      if (in_valid && in_ready) begin
        e.data = model(in_imm, in_mode);
        e.tag  = in_tag;
        sb.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    exp_cnt = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [15:0] va [6] = '{16'h8000, 16'h8000, 16'h7FFF, 16'h1234, 16'hFFFF, 16'h0001};
  logic [1:0]  vm [6] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd3};
  logic [31:0] ve [6] = '{32'hFFFF8000, 32'h00008000, 32'h00007FFF,
                          32'h12340000, 32'hFFFFFFFC, 32'h00000004};

  initial begin
    // Reset state, checked before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_data", {32'd0, out_data}, 64'd0);
    chk("rst_out_tag", {59'd0, out_tag}, 64'd0);
    chk("rst_count", {48'd0, xfer_count}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Modes and single-item latency.
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_imm = va[i]; in_mode = vm[i]; in_tag = 5'(i + 1);
      step();
      in_valid = 1'b0; in_imm = 16'($urandom); in_mode = 2'($urandom);
      chk("lat_valid", {63'd0, out_valid}, 64'd1);
      chk("mode_data", {32'd0, out_data}, {32'd0, ve[i]});
      chk("mode_tag", {59'd0, out_tag}, 64'(i + 1));
      step();
      chk("drain_valid", {63'd0, out_valid}, 64'd0);
      chk("retain_data", {32'd0, out_data}, {32'd0, ve[i]});
      chk("empty_ready", {63'd0, in_ready}, 64'd1);
    end
    chk("count_after_modes", {48'd0, xfer_count}, 64'd6);

    // Back-pressure: tags 1,2,3 offered while downstream stalls.
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm = 16'h0010; in_mode = 2'd0; in_tag = 5'd1;
    step();
    chk("bp_one_ready", {63'd0, in_ready}, 64'd1);
    in_imm = 16'h8001; in_mode = 2'd1; in_tag = 5'd2;
    step();
    chk("bp_two_ready", {63'd0, in_ready}, 64'd0);
    in_imm = 16'hC000; in_mode = 2'd3; in_tag = 5'd3;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("bp_hold_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_hold_tag", {59'd0, out_tag}, 64'd1);
      chk("bp_hold_data", {32'd0, out_data}, 64'h00000010);
    end
    out_ready = 1'b1;
    step();
    chk("bp_tag2", {59'd0, out_tag}, 64'd2);
    chk("bp_data2", {32'd0, out_data}, 64'h00008001);
    chk("bp_ready_back", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    chk("bp_tag3", {59'd0, out_tag}, 64'd3);
    chk("bp_data3", {32'd0, out_data}, 64'hFFFF0000);
    step();
    chk("bp_empty", {63'd0, out_valid}, 64'd0);
    chk("count_after_bp", {48'd0, xfer_count}, 64'd9);

    // Full throughput: 8 back-to-back items.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_imm = 16'($urandom); in_mode = 2'(i); in_tag = 5'(i + 10);
      step();
      chk("tp_valid", {63'd0, out_valid}, 64'd1);
      chk("tp_ready", {63'd0, in_ready}, 64'd1);
      chk("tp_tag", {59'd0, out_tag}, 64'(i + 10));
    end
    in_valid = 1'b0;
    step();
    chk("tp_count", {48'd0, xfer_count}, 64'd8);
    chk("tp_count4", {60'd0, xfer_count4}, 64'd8);

    // Asynchronous reset while holding two items.
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm = 16'h1111; in_mode = 2'd1; in_tag = 5'd4;
    step();
    in_tag = 5'd5;
    step();
    in_valid = 1'b0;
    chk("ar_full", {63'd0, in_ready}, 64'd0);
    #2 rst_n = 1'b0;
    sb.delete();
    exp_cnt = 0;
    #1;
    chk("ar_valid", {63'd0, out_valid}, 64'd0);
    chk("ar_ready", {63'd0, in_ready}, 64'd1);
    chk("ar_count", {48'd0, xfer_count}, 64'd0);
    chk("ar_data", {32'd0, out_data}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_imm = 16'h0005; in_mode = 2'd2; in_tag = 5'd7;
    step();
    in_valid = 1'b0;
    chk("ar_lat_valid", {63'd0, out_valid}, 64'd1);
    chk("ar_lat_data", {32'd0, out_data}, 64'h00050000);
    step();
    chk("ar_lat_drain", {63'd0, out_valid}, 64'd0);

    // Counter wrap on the 4-bit instance.
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      in_valid = 1'b1; in_imm = 16'($urandom); in_mode = 2'($urandom); in_tag = 5'(i);
      step();
      if (i == 16) chk("wrap_15", {60'd0, xfer_count4}, 64'd15);
      if (i == 17) chk("wrap_16", {60'd0, xfer_count4}, 64'd0);
    end
    in_valid = 1'b0;
    step();
    chk("wrap_17", {60'd0, xfer_count4}, 64'd1);
    chk("wrap_wide", {48'd0, xfer_count}, 64'd17);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 Parameter IN_W, default 16, width of the raw immediate field.
REQ-002 Parameter OUT_W, default 32, width of the extended result; legal only when OUT_W >= IN_W+2.
REQ-003 Parameter TAG_W, default 5, width of the sideband tag carried with each item (e.g. destination register).
REQ-004 Parameter COUNT_W, default 16, width of the transfer counter.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  upstream item present.
REQ-008 in_ready  output  1  block can accept an item this cycle.
REQ-009 in_imm  input  IN_W  raw immediate.
REQ-010 in_mode  input  2  extension mode (see REQ-014).
REQ-011 in_tag  input  TAG_W  sideband tag.
REQ-012 out_valid / out_ready  output / input  1 each  downstream handshake.
REQ-013 out_data  output  OUT_W; out_tag  output  TAG_W; xfer_count  output  COUNT_W.

Function
REQ-014 Modes, computed on the accepted in_imm:
- 00 sign-extend: MSB of in_imm replicated into bits OUT_W-1..IN_W.
- 01 zero-extend: upper OUT_W-IN_W bits zero.
- 10 upper-load: in_imm placed in bits OUT_W-1..OUT_W-IN_W, lower bits zero.
- 11 branch-offset: sign-extend, then shift left 2, upper bits beyond OUT_W discarded (no loss given REQ-002).
REQ-015 Input transfer occurs on a clock edge where in_valid && in_ready; output transfer where out_valid && out_ready.
REQ-016 Latency: an item accepted into an empty block appears on out_data/out_tag with out_valid=1 the cycle after acceptance.
REQ-017 Storage: one output register plus one skid register; state machine EMPTY (0 held), ONE (output reg full), TWO (both full).
REQ-018 in_ready SHALL be a registered signal: 1 in EMPTY and ONE, 0 in TWO; it never depends combinationally on out_ready.
REQ-019 Transitions:
- EMPTY + in xfer -> ONE.
- ONE + in xfer, no out xfer -> TWO (new item to skid).
- ONE + out xfer, no in xfer -> EMPTY.
- ONE + in and out xfer same edge -> ONE, output reg loads new item (throughput 1 item/cycle).
- TWO + out xfer -> ONE, skid moves to output reg.
- TWO, no out xfer -> TWO.
REQ-020 Items leave in acceptance order; none dropped or duplicated.
REQ-021 While out_valid=1 and out_ready=0, out_data and out_tag SHALL hold stable.
REQ-022 out_valid=1 exactly in ONE and TWO.
REQ-023 in_imm/in_mode/in_tag are ignored on edges without an input transfer.
REQ-024 xfer_count increments by 1 on each output transfer; wraps from all-ones to 0.
REQ-025 out_data/out_tag SHALL retain their last value when returning to EMPTY.

Reset
REQ-026 While reset_n=0, asynchronously: state EMPTY, out_valid=0, out_data=0, out_tag=0, xfer_count=0, in_ready=1, skid contents cleared.
REQ-027 Reset asserted mid-operation (ONE or TWO) discards all held items; first item after release follows REQ-016 timing.

Verification
REQ-028 IN_W=16/OUT_W=32: in_imm=0x8000 mode 00 -> out_data 0xFFFF8000; same imm mode 01 -> 0x00008000; 0x7FFF mode 00 -> 0x00007FFF.
REQ-029 in_imm=0x1234 mode 10 -> 0x12340000; 0xFFFF mode 11 -> 0xFFFFFFFC; 0x0001 mode 11 -> 0x00000004.
REQ-030 out_ready=0, offer tags 1,2,3 back-to-back -> 1,2 accepted, in_ready=0 after second; raise out_ready -> outputs tags 1,2,3 in order, no loss.
REQ-031 out_ready=1, in_valid=1 for 8 cycles -> 8 results on 8 consecutive cycles, state remains ONE, xfer_count=8.
REQ-032 State TWO, pulse reset_n low -> out_valid=0, in_ready=1, xfer_count=0 immediately, before next clock edge.
REQ-033 COUNT_W=4, 17 output transfers -> xfer_count reads 0 after the 16th, 1 after the 17th.
